msg_stream_merge: RTL
=====================

# msg_stream_merge

Merges the `qa_contents` message stream back into a sample stream so that one output port carries both the pass-through samples and the queued report messages. Samples are never delayed by more than one cycle. Messages are buffered in an internal FIFO and emitted in idle slots, with a per-word flag that marks which output words are messages. Sits directly downstream of `qa_contents`, taking its `out_data`/`out_nd` and `out_msg`/`out_msg_nd` outputs.

## Interface
- `WIDTH`, 32: sample width; output word width.
- `MSG_WIDTH`, 32: message word width; must be ≤ `WIDTH`.
- `LOG_DEPTH`, 4: log2 of the message FIFO depth (depth = 2^`LOG_DEPTH`).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  `WIDTH`  sample word.
- `in_nd`  in  1  `in_data` is valid this cycle.
- `in_msg`  in  `MSG_WIDTH`  message word.
- `in_msg_nd`  in  1  `in_msg` is valid this cycle.
- `out_data`  out  `WIDTH`  merged output word.
- `out_nd`  out  1  `out_data` is valid.
- `out_is_msg`  out  1  the valid word is a message word; 0 when it is a sample.
- `msg_pending`  out  1  the FIFO is non-empty.
- `error`  out  1  sticky flag: a message word was dropped.

## Operation
- **Reset:** all outputs go to 0, both FIFO pointers go to 0 and the occupancy count goes to 0.
- **Priority:** samples win. At each edge the output is chosen in this order:
  1. If `in_nd`=1, output the sample: `out_data` ← `in_data`, `out_nd` ← 1, `out_is_msg` ← 0.
  2. Else, if the FIFO is non-empty, pop the head word: `out_data` ← head zero-extended to `WIDTH`, `out_nd` ← 1, `out_is_msg` ← 1.
  3. Else, `out_nd` ← 0 and `out_is_msg` ← 0; `out_data` holds its last value.
- **FIFO:**
  - Circular buffer with depth 2^`LOG_DEPTH`.
  - Pointers are `LOG_DEPTH` bits wide and wrap naturally.
  - Occupancy count is `LOG_DEPTH`+1 bits wide.
  - A push happens at an edge where `in_msg_nd`=1.
  - Message order is preserved. Messages are never reordered among themselves.
- **Simultaneous push and pop:** both take effect in the same edge and the count is unchanged. This is legal even when the FIFO is full.
- **Push when full with no pop in that edge:** the word is dropped, pointers and count are unchanged, and `error` ← 1. `error` stays high until `rst`.
- **Push while empty with a pop in the same edge:** the pop sees the empty state, so nothing is popped. The word is stored and is eligible for output from the next edge.
- **`msg_pending`:** registered; equals (count ≠ 0) after each edge.
- **Reset mid-stream:** all queued messages are discarded. After `rst` is released, the block behaves as if freshly reset.

## Timing
- Sample latency: 1 cycle. `in_nd` high at edge k gives `out_nd` high after edge k.
- Minimum message latency: 2 cycles. A push at edge k allows output after edge k+1, provided `in_nd`=0 at edge k+1.
- Maximum throughput is one output word per cycle. With continuous samples, messages wait indefinitely.
- No backpressure is available on any port.

## Configuration
- `MSG_STREAM_MERGE_DROP_CNT_EN` defined:
  - Adds output port `drop_count` (`out`, 16 bits).
  - It increments on every dropped message word, saturates at 16'hFFFF and resets to 0.
  - `error` behaves exactly as without the macro.
- Macro undefined: the `drop_count` port and its logic do not exist.

## Test plan
- **Sample pass-through:** `in_data`=32'h00000011, `in_nd`=1 for 1 cycle → next cycle `out_data`=32'h00000011, `out_nd`=1, `out_is_msg`=0.
- **Message in idle gap:** push `in_msg`=32'hCAFE0001 with `in_nd`=0 throughout → 2 cycles later `out_data`=32'hCAFE0001, `out_nd`=1, `out_is_msg`=1; `msg_pending` falls after the pop.
- **Samples block messages:** push 3 messages, then hold `in_nd`=1 for 10 cycles with data 1..10 → output is 1..10 (`out_is_msg`=0), then the 3 messages in order.
- **Overflow:** with `in_nd`=1 continuously and `LOG_DEPTH`=4, push 17 messages → `error`=1 after the 17th push. The first 16 messages emerge after `in_nd` drops. With the macro defined, `drop_count`=1.
- **Full FIFO, simultaneous push and pop:** fill 16 messages, then drop `in_nd` while pushing 1 more → no error; 17 messages emerge in order.
- **Reset mid-operation:** with 5 messages queued, pulse `rst` for 1 cycle → all outputs are 0, `msg_pending`=0 and no messages emerge.

Source files
------------

// File: rtl/msg_stream_merge.sv
// msg_stream_merge: merges a sample stream and a message stream onto a single
// output port. Samples always win the slot and go out one cycle after input.
// Messages are queued in a circular FIFO and sent in idle slots, tagged with
// out_is_msg. If a message arrives while the FIFO is full and nothing pops in
// that cycle, the word is dropped and the sticky error flag is set.
//
// Optional feature: define MSG_STREAM_MERGE_DROP_CNT_EN to add a saturating
// 16-bit drop_count output that counts dropped message words.
module msg_stream_merge #(
   parameter int WIDTH     = 32,
   parameter int MSG_WIDTH = 32,
   parameter int LOG_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_nd,
   input  logic [MSG_WIDTH-1:0] in_msg,
   input  logic                 in_msg_nd,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_nd,
   output logic                 out_is_msg,
   output logic                 msg_pending,
`ifdef MSG_STREAM_MERGE_DROP_CNT_EN
   output logic                 error,
   output logic [15:0]          drop_count
`else
   output logic                 error
`endif
);

   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [MSG_WIDTH-1:0] r_mem [DEPTH];
   logic [LOG_DEPTH-1:0] r_wr_ptr;
   logic [LOG_DEPTH-1:0] r_rd_ptr;
   logic [LOG_DEPTH:0]   r_count;

   logic [WIDTH-1:0]     r_out_data;
   logic                 r_out_nd;
   logic                 r_out_is_msg;
   logic                 r_msg_pending;
   logic                 r_error;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [LOG_DEPTH:0]   w_count_nxt;
   logic [WIDTH-1:0]     w_head_ext;

   // FIFO status and the push/pop/drop decisions for this edge.
   // A pop only happens when no sample claims the slot; a pop frees room for
   // a push arriving in the same cycle even when the FIFO is full.
   always_comb begin
      w_empty = (r_count == '0);
      w_full  = (r_count == (LOG_DEPTH+1)'(DEPTH));
      w_pop   = !in_nd && !w_empty;
      w_push  = in_msg_nd && (!w_full || w_pop);
      w_drop  = in_msg_nd && w_full && !w_pop;
   end

   // Next occupancy: simultaneous push and pop leaves the count unchanged.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + (LOG_DEPTH+1)'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - (LOG_DEPTH+1)'(1);
      end
   end

   // Head word zero-extended to the output width (works for MSG_WIDTH == WIDTH).
   always_comb begin
      w_head_ext                  = '0;
      w_head_ext[MSG_WIDTH-1:0]   = r_mem[r_rd_ptr];
   end

   // Message storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_msg;
      end
   end

   // FIFO pointers, occupancy and the registered pending flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_msg_pending <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
         end
         r_count       <= w_count_nxt;
         r_msg_pending <= (w_count_nxt != '0);
      end
   end

   // Output slot selection: sample first, then queued message, else idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data   <= '0;
         r_out_nd     <= 1'b0;
         r_out_is_msg <= 1'b0;
      end else if (in_nd) begin
         r_out_data   <= in_data;
         r_out_nd     <= 1'b1;
         r_out_is_msg <= 1'b0;
      end else if (w_pop) begin
         r_out_data   <= w_head_ext;
         r_out_nd     <= 1'b1;
         r_out_is_msg <= 1'b1;
      end else begin
         r_out_nd     <= 1'b0;
         r_out_is_msg <= 1'b0;
      end
   end

   // Sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_error <= 1'b0;
      end else if (w_drop) begin
         r_error <= 1'b1;
      end
   end

`ifdef MSG_STREAM_MERGE_DROP_CNT_EN
   logic [15:0] r_drop_count;

   // Saturating count of dropped message words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign drop_count = r_drop_count;
`endif

   assign out_data    = r_out_data;
   assign out_nd      = r_out_nd;
   assign out_is_msg  = r_out_is_msg;
   assign msg_pending = r_msg_pending;
   assign error       = r_error;

endmodule
